// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full adder and one carry flop are
// reused across WIDTH cycles to form a WIDTH-bit sum or difference.
module serial_addsub_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic [1:0]       o_dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             r_ovf;
   logic             r_live;

   logic w_a_bit;
   logic w_b_bit;
   logic w_sum;
   logic w_cy;
   logic w_last;
   logic w_accept;
   logic w_release;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready/out_valid depend only on state, never on the inputs.
   assign w_a_bit   = r_a[0];
   assign w_b_bit   = r_b[0];
   assign w_sum     = w_a_bit ^ w_b_bit ^ r_carry;
   assign w_cy      = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);
   assign w_last    = (r_cnt == LAST_BIT);
   assign w_accept  = r_live && (r_state == S_IDLE) && in_valid;
   assign w_release = (r_state == S_DONE) && out_ready;

   // r_live keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept)  r_state <= S_RUN;
            S_RUN:   if (w_last)    r_state <= S_DONE;
            S_DONE:  if (w_release) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
      end else if (w_accept) begin
         // Subtract is A + ~B + 1: invert B and seed the carry with op_sub.
         r_cnt   <= '0;
         r_carry <= op_sub;
         r_a     <= a;
         r_b     <= op_sub ? ~b : b;
      end else if (r_state == S_RUN) begin
         r_cnt   <= r_cnt + CNT_ONE;
         r_carry <= w_cy;
         r_a     <= {1'b0, r_a[WIDTH-1:1]};
         r_b     <= {1'b0, r_b[WIDTH-1:1]};
         r_res   <= {w_sum, r_res[WIDTH-1:1]};
      end
   end

   // On the MSB edge the carry flop holds the carry into the MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_cout <= w_cy;
         r_ovf  <= r_carry ^ w_cy;
      end
   end

   assign in_ready    = r_live && (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign result      = r_res;
   assign cout        = r_cout;
   assign ovf         = r_ovf;
   assign zero        = r_live && (r_res == '0);
   assign o_dbg_state = r_state;

endmodule
